// File: rtl/bp_nonsynth_host_io_master.sv
// Bench-side host I/O initiator: turns putchar/getchar/finish requests into uncached memory
// commands for the host I/O responder, waits for the response and reports completion.
// Only one transaction is ever outstanding, and every transaction is guarded by a watchdog.
// The processor configuration is flattened into plain parameters. The message layout is
// (MSB..LSB) data | payload | size | addr | msg_type.
module bp_nonsynth_host_io_master
  #(parameter int unsigned paddr_width_p     = 40
    , parameter int unsigned cce_block_width_p = 64
    , parameter int unsigned payload_width_p   = 12
    , parameter int unsigned num_core_p        = 4
    , parameter int unsigned timeout_p         = 1024
    , localparam int unsigned core_width_lp    = (num_core_p > 1) ? $clog2(num_core_p) : 1
    , localparam int unsigned cce_mem_msg_width_lp =
        cce_block_width_p + payload_width_p + 3 + paddr_width_p + 4
    )
    (input  logic                            clk_i
     , input  logic                            reset_i
     , input  logic                            req_v_i
     , output logic                            req_ready_o
     , input  logic [1:0]                      req_op_i
     , input  logic [core_width_lp-1:0]        req_core_i
     , input  logic [7:0]                      req_data_i
     , output logic [cce_mem_msg_width_lp-1:0] io_cmd_o
     , output logic                            io_cmd_v_o
     , input  logic                            io_cmd_yumi_i
     , input  logic [cce_mem_msg_width_lp-1:0] io_resp_i
     , input  logic                            io_resp_v_i
     , output logic                            io_resp_yumi_o
     , output logic                            rsp_v_o
     , output logic [7:0]                      rsp_data_o
     , output logic                            error_o
     , output logic [31:0]                     txn_count_o
     );

    localparam logic [3:0] mem_uc_rd_lp  = 4'd2;
    localparam logic [3:0] mem_uc_wr_lp  = 4'd3;
    localparam logic [2:0] mem_size_8_lp = 3'd3;

    localparam int unsigned timer_width_lp = (timeout_p > 1) ? $clog2(timeout_p) : 1;
    localparam logic [timer_width_lp-1:0] timer_max_lp = timer_width_lp'(timeout_p - 1);

    typedef struct packed {
        logic [cce_block_width_p-1:0] data;
        logic [payload_width_p-1:0]   payload;
        logic [2:0]                   size;
        logic [paddr_width_p-1:0]     addr;
        logic [3:0]                   msg_type;
    } mem_msg_s;

    typedef enum logic [1:0] {StIdle, StSend, StWait, StDone} state_e;

    state_e                    state_q, state_d;
    mem_msg_s                  cmd_q, cmd_d, new_cmd, resp;
    logic [timer_width_lp-1:0] timer_q, timer_d;
    logic [7:0]                rsp_data_q, rsp_data_d;
    logic                      error_q, error_d;
    logic [31:0]               txn_count_q, txn_count_d;
    logic                      timeout, resp_mismatch, accept;
    logic                      unused_resp;

    assign resp          = mem_msg_s'(io_resp_i);
    assign resp_mismatch = (resp.msg_type != cmd_q.msg_type) || (resp.addr != cmd_q.addr);
    assign timeout       = (state_q inside {StSend, StWait}) && (timer_q == timer_max_lp);
    assign accept        = (state_q == StIdle) && req_v_i && (req_op_i != 2'd3);
    assign unused_resp   = ^{resp.payload, resp.size, resp.data[cce_block_width_p-1:8]};

    // Encode the incoming request as a host-mapped uncached command
    always_comb begin
        new_cmd      = '0;
        new_cmd.size = mem_size_8_lp;
        unique case (req_op_i)
            2'd0: begin
                new_cmd.msg_type = mem_uc_wr_lp;
                new_cmd.addr     = paddr_width_p'(64'h0010_1000);
                new_cmd.data     = cce_block_width_p'(req_data_i);
            end
            2'd1: begin
                new_cmd.msg_type = mem_uc_rd_lp;
                new_cmd.addr     = paddr_width_p'(64'h0010_0000 | (64'(req_core_i) << 3));
            end
            2'd2: begin
                new_cmd.msg_type = mem_uc_wr_lp;
                new_cmd.addr     = paddr_width_p'(64'h0010_2000 | (64'(req_core_i) << 3));
                new_cmd.data     = cce_block_width_p'(req_data_i[0]);
            end
            2'd3: ;
        endcase
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (reset_i) state_q <= StIdle;
        else         state_q <= state_d;
    end

    // Next-state logic; a response beats a timeout landing in the same cycle
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (accept) state_d = StSend;
            StSend: begin
                if (io_cmd_yumi_i) state_d = StWait;
                else if (timeout)  state_d = StDone;
            end
            StWait: if (io_resp_v_i || timeout) state_d = StDone;
            StDone: state_d = StIdle;
        endcase
    end

    // Handshake outputs decoded from the current state
    always_comb begin
        req_ready_o    = 1'b0;
        io_cmd_v_o     = 1'b0;
        io_resp_yumi_o = 1'b0;
        rsp_v_o        = 1'b0;
        unique case (state_q)
            StIdle: begin
                req_ready_o    = 1'b1;
                io_resp_yumi_o = io_resp_v_i;  // stray responses are drained
            end
            StSend: io_cmd_v_o     = 1'b1;
            StWait: io_resp_yumi_o = io_resp_v_i;
            StDone: rsp_v_o        = 1'b1;
        endcase
    end

    // Datapath next state: command, watchdog, completion data, sticky error, counter
    always_comb begin
        cmd_d       = accept ? new_cmd : cmd_q;
        timer_d     = '0;
        rsp_data_d  = rsp_data_q;
        error_d     = error_q;
        txn_count_d = txn_count_q;
        unique case (state_q)
            StIdle: begin
                if (io_resp_v_i || (req_v_i && (req_op_i == 2'd3))) error_d = 1'b1;
            end
            StSend: begin
                if (!io_cmd_yumi_i) begin
                    timer_d = timer_q + timer_width_lp'(1);
                    if (timeout) begin
                        error_d    = 1'b1;
                        rsp_data_d = 8'h00;
                    end
                end
            end
            StWait: begin
                timer_d = timer_q + timer_width_lp'(1);
                if (io_resp_v_i) begin
                    rsp_data_d = (cmd_q.msg_type == mem_uc_rd_lp) ? resp.data[7:0] : 8'h00;
                    if (resp_mismatch) error_d = 1'b1;
                end else if (timeout) begin
                    error_d    = 1'b1;
                    rsp_data_d = 8'h00;
                end
            end
            StDone: txn_count_d = txn_count_q + 32'd1;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cmd_q       <= '0;
            timer_q     <= '0;
            rsp_data_q  <= 8'h00;
            error_q     <= 1'b0;
            txn_count_q <= 32'd0;
        end else begin
            cmd_q       <= cmd_d;
            timer_q     <= timer_d;
            rsp_data_q  <= rsp_data_d;
            error_q     <= error_d;
            txn_count_q <= txn_count_d;
        end
    end

    assign io_cmd_o    = cmd_q;
    assign rsp_data_o  = rsp_data_q;
    assign error_o     = error_q;
    assign txn_count_o = txn_count_q;

endmodule
